// File: rtl/ascon_perm_ctrl.sv
// Round sequencer for the 320-bit ASCON permutation datapath.
// Runs p12 (rounds 0..11) or p6 (rounds 6..11) per accepted start and drives registered Moore outputs.
module ascon_perm_ctrl #(
    parameter int ROUND_W    = 4,
    parameter int LAST_ROUND = 11,
    parameter int P12_FIRST  = 0,
    parameter int P6_FIRST   = LAST_ROUND - 5
) (
    input  logic               clock_i,
    input  logic               resetb_i,
    input  logic               start_i,
    input  logic               mode_i,
    output logic [ROUND_W-1:0] round_o,
    output logic               data_sel_o,
    output logic               en_reg_state_o,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_ROUND_FIRST = 2'd1,
        ST_ROUND_RUN   = 2'd2,
        ST_DONE        = 2'd3
    } state_t;

    localparam logic [ROUND_W-1:0] ROUND_ZERO = ROUND_W'(0);
    localparam logic [ROUND_W-1:0] ROUND_ONE  = ROUND_W'(1);
    localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(LAST_ROUND);
    localparam logic [ROUND_W-1:0] ROUND_P12  = ROUND_W'(P12_FIRST);
    localparam logic [ROUND_W-1:0] ROUND_P6   = ROUND_W'(P6_FIRST);

    state_t             state_r;
    state_t             next_state_s;
    logic [ROUND_W-1:0] round_next_s;
    logic               data_sel_next_s;
    logic               en_next_s;
    logic               busy_next_s;
    logic               done_next_s;

    // State and round-index register; round_o is the register itself.
    always_ff @(posedge clock_i or posedge resetb_i) begin
        if (resetb_i) begin
            state_r <= ST_IDLE;
            round_o <= ROUND_ZERO;
        end else begin
            state_r <= next_state_s;
            round_o <= round_next_s;
        end
    end

    // Next-state and next-round selection.
    always_comb begin
        next_state_s = ST_IDLE;
        round_next_s = ROUND_ZERO;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                // DONE behaves like IDLE for a new request, which gives back-to-back runs.
                if (start_i) begin
                    next_state_s = ST_ROUND_FIRST;
                    round_next_s = mode_i ? ROUND_P6 : ROUND_P12;
                end else begin
                    next_state_s = ST_IDLE;
                    round_next_s = ROUND_ZERO;
                end
            end
            ST_ROUND_FIRST: begin
                if (round_o >= ROUND_LAST) begin
                    next_state_s = ST_DONE;
                    round_next_s = ROUND_LAST;
                end else begin
                    next_state_s = ST_ROUND_RUN;
                    round_next_s = round_o + ROUND_ONE;
                end
            end
            ST_ROUND_RUN: begin
                // Saturating compare keeps the index inside 0..LAST_ROUND even on a corrupted value.
                if (round_o >= ROUND_LAST) begin
                    next_state_s = ST_DONE;
                    round_next_s = ROUND_LAST;
                end else begin
                    next_state_s = ST_ROUND_RUN;
                    round_next_s = round_o + ROUND_ONE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                round_next_s = ROUND_ZERO;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with state_r.
    always_comb begin
        data_sel_next_s = 1'b0;
        en_next_s       = 1'b0;
        busy_next_s     = 1'b0;
        done_next_s     = 1'b0;
        case (next_state_s)
            ST_IDLE: begin
                data_sel_next_s = 1'b0;
                en_next_s       = 1'b0;
                busy_next_s     = 1'b0;
                done_next_s     = 1'b0;
            end
            ST_ROUND_FIRST: begin
                data_sel_next_s = 1'b0;
                en_next_s       = 1'b1;
                busy_next_s     = 1'b1;
                done_next_s     = 1'b0;
            end
            ST_ROUND_RUN: begin
                data_sel_next_s = 1'b1;
                en_next_s       = 1'b1;
                busy_next_s     = 1'b1;
                done_next_s     = 1'b0;
            end
            ST_DONE: begin
                data_sel_next_s = 1'b1;
                en_next_s       = 1'b0;
                busy_next_s     = 1'b0;
                done_next_s     = 1'b1;
            end
            default: begin
                data_sel_next_s = 1'b0;
                en_next_s       = 1'b0;
                busy_next_s     = 1'b0;
                done_next_s     = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clock_i or posedge resetb_i) begin
        if (resetb_i) begin
            data_sel_o     <= 1'b0;
            en_reg_state_o <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
        end else begin
            data_sel_o     <= data_sel_next_s;
            en_reg_state_o <= en_next_s;
            busy_o         <= busy_next_s;
            done_o         <= done_next_s;
        end
    end

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Table-driven bench for ascon_perm_ctrl: per-cycle vectors plus a hand-written async reset sequence.
module tb_ascon_perm_ctrl;

    logic       clock_i = 1'b0;
    logic       resetb_i;
    logic       start_i;
    logic       mode_i;
    logic [3:0] round_o;
    logic       data_sel_o;
    logic       en_reg_state_o;
    logic       busy_o;
    logic       done_o;

    int n_checks = 0;
    int n_errors = 0;

    ascon_perm_ctrl dut (
        .clock_i        (clock_i),
        .resetb_i       (resetb_i),
        .start_i        (start_i),
        .mode_i         (mode_i),
        .round_o        (round_o),
        .data_sel_o     (data_sel_o),
        .en_reg_state_o (en_reg_state_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic       start;
        logic       mode;
        logic       chk_round;
        logic [3:0] round;
        logic       sel;
        logic       en;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic st, input logic md, input logic cr, input logic [3:0] rd,
                                input logic sl, input logic e, input logic b, input logic d);
        vec_t v;
        v.start = st; v.mode = md; v.chk_round = cr; v.round = rd;
        v.sel = sl; v.en = e; v.busy = b; v.done = d;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] rd, input logic sl,
                             input logic e, input logic b, input logic d);
        check({tag, " round"}, {4'd0, round_o}, {4'd0, rd});
        check({tag, " data_sel"}, {7'd0, data_sel_o}, {7'd0, sl});
        check({tag, " en"}, {7'd0, en_reg_state_o}, {7'd0, e});
        check({tag, " busy"}, {7'd0, busy_o}, {7'd0, b});
        check({tag, " done"}, {7'd0, done_o}, {7'd0, d});
    endtask

    initial begin
        bit found;
        int guard;

        // Idle with start low.
        for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // p12: first round takes external state, then 11 feedback rounds, then done.
        add(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int r = 1; r <= 11; r++) add(1'b0, 1'b0, 1'b1, 4'(r), 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 4'd11, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // p6: rounds 6..11.
        add(1'b1, 1'b1, 1'b1, 4'd6, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int r = 7; r <= 11; r++) add(1'b0, 1'b0, 1'b1, 4'(r), 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 4'd11, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // start held high with p6: runs separated by a single DONE cycle.
        for (int k = 0; k < 3; k++) begin
            add(1'b1, 1'b1, 1'b1, 4'd6, 1'b0, 1'b1, 1'b1, 1'b0);
            for (int r = 7; r <= 11; r++) add(1'b1, 1'b1, 1'b1, 4'(r), 1'b1, 1'b1, 1'b1, 1'b0);
            add(1'b1, 1'b1, 1'b1, 4'd11, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        add(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // p12 with a p6 start pulse while round 5 is showing: ignored.
        add(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int r = 1; r <= 11; r++)
            add((r == 6), (r == 6), 1'b1, 4'(r), 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 4'd11, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        resetb_i = 1'b1;
        start_i  = 1'b0;
        mode_i   = 1'b0;
        #12;
        check_all("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock_i);
        resetb_i = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clock_i);
            start_i = vecs[i].start;
            mode_i  = vecs[i].mode;
            @(posedge clock_i);
            #1;
            if (vecs[i].chk_round)
                check($sformatf("vec%0d round", i), {4'd0, round_o}, {4'd0, vecs[i].round});
            check($sformatf("vec%0d data_sel", i), {7'd0, data_sel_o}, {7'd0, vecs[i].sel});
            check($sformatf("vec%0d en", i), {7'd0, en_reg_state_o}, {7'd0, vecs[i].en});
            check($sformatf("vec%0d busy", i), {7'd0, busy_o}, {7'd0, vecs[i].busy});
            check($sformatf("vec%0d done", i), {7'd0, done_o}, {7'd0, vecs[i].done});
        end

        // Async reset in the middle of a p12 run at round 8, between clock edges.
        @(negedge clock_i);
        start_i = 1'b1;
        mode_i  = 1'b0;
        @(posedge clock_i);
        #1;
        start_i = 1'b0;
        found = 1'b0;
        guard = 0;
        while (!found && guard < 20) begin
            if (round_o == 4'd8) found = 1'b1;
            else begin
                @(posedge clock_i);
                #1;
                guard++;
            end
        end
        check("reach round 8", {7'd0, found}, 8'd1);
        #2;
        resetb_i = 1'b1;
        #1;
        check_all("async reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clock_i);
        #1;
        check_all("reset held", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock_i);
        resetb_i = 1'b0;
        start_i  = 1'b1;
        mode_i   = 1'b0;
        @(posedge clock_i);
        #1;
        check_all("restart first", 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clock_i);
        start_i = 1'b0;
        @(posedge clock_i);
        #1;
        check_all("restart second", 4'd1, 1'b1, 1'b1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
